vga_grid_renderer: RTL and testbench



---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_timing.sv | 83 ++++++++
 rtl/vga_grid_renderer.sv | 135 +++++++++++++
 tb/tb_vga_grid_renderer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : 640x480@60 timing constants and the 12-bit colour type.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int c_H_ACTIVE = 640;
  localparam int c_H_FP     = 16;
  localparam int c_H_SYNC   = 96;
  localparam int c_H_BP     = 48;
  localparam int c_V_ACTIVE = 480;
  localparam int c_V_FP     = 10;
  localparam int c_V_SYNC   = 2;
  localparam int c_V_BP     = 33;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COLOR_BLACK = 12'h000;
  localparam rgb_t COLOR_WHITE = 12'hFFF;
  localparam rgb_t COLOR_RED   = 12'hF00;

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Purpose  : Pixel tick divider, raster counters and raw sync/active flags.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = c_H_ACTIVE,
  parameter int H_FP     = c_H_FP,
  parameter int H_SYNC   = c_H_SYNC,
  parameter int H_BP     = c_H_BP,
  parameter int V_ACTIVE = c_V_ACTIVE,
  parameter int V_FP     = c_V_FP,
  parameter int V_SYNC   = c_V_SYNC,
  parameter int V_BP     = c_V_BP,
  parameter int CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       o_pix_en,
  output logic [9:0] o_hcnt,
  output logic [9:0] o_vcnt,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic       o_active,
  output logic       o_frame_end
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

  logic [c_DIV_W-1:0] r_div;
  logic [9:0]         r_hcnt;
  logic [9:0]         r_vcnt;
  logic               w_pix_en;
  logic               w_line_end;
  logic               w_last_line;

  // With CLK_DIV=1 the divider sits at zero, which is also its last value.
  assign w_pix_en    = (r_div == c_DIV_LAST);
  assign w_line_end  = (r_hcnt == 10'(c_H_TOTAL - 1));
  assign w_last_line = (r_vcnt == 10'(c_V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_pix_en) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + c_DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_pix_en) begin
      if (w_line_end) begin
        r_hcnt <= '0;
        r_vcnt <= w_last_line ? 10'd0 : r_vcnt + 10'd1;
      end else begin
        r_hcnt <= r_hcnt + 10'd1;
      end
    end
  end

  assign o_pix_en    = w_pix_en;
  assign o_hcnt      = r_hcnt;
  assign o_vcnt      = r_vcnt;
  assign o_frame_end = w_line_end && w_last_line;
  assign o_hsync_n   = !((r_hcnt >= 10'(H_ACTIVE + H_FP)) &&
                         (r_hcnt <  10'(H_ACTIVE + H_FP + H_SYNC)));
  assign o_vsync_n   = !((r_vcnt >= 10'(V_ACTIVE + V_FP)) &&
                         (r_vcnt <  10'(V_ACTIVE + V_FP + V_SYNC)));
  assign o_active    = (r_hcnt < 10'(H_ACTIVE)) && (r_vcnt < 10'(V_ACTIVE));

endmodule
`default_nettype wire

// File: rtl/vga_grid_renderer.sv
`default_nettype none
// ============================================================================
// Module   : vga_grid_renderer
// Purpose  : 2x2 grid display with a highlighted player cell on VGA.
// Revision : 1.0 - initial release
// ============================================================================
module vga_grid_renderer
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = c_H_ACTIVE,
  parameter int   H_FP       = c_H_FP,
  parameter int   H_SYNC     = c_H_SYNC,
  parameter int   H_BP       = c_H_BP,
  parameter int   V_ACTIVE   = c_V_ACTIVE,
  parameter int   V_FP       = c_V_FP,
  parameter int   V_SYNC     = c_V_SYNC,
  parameter int   V_BP       = c_V_BP,
  parameter int   CLK_DIV    = 2,
  parameter rgb_t PLAYER_RGB = COLOR_RED,
  parameter rgb_t GRID_RGB   = COLOR_WHITE
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       X,
  input  logic       Y,
  output logic       HSync,
  output logic       VSync,
  output logic [3:0] Red,
  output logic [3:0] Green,
  output logic [3:0] Blue,
  output logic       Active,
  output logic [9:0] PixelX,
  output logic [9:0] PixelY,
  output logic       FrameStart
);

  logic       w_pix_en;
  logic [9:0] w_hcnt;
  logic [9:0] w_vcnt;
  logic       w_hsync_n;
  logic       w_vsync_n;
  logic       w_active;
  logic       w_frame_end;
  rgb_t       w_rgb;

  logic       r_x_q;
  logic       r_y_q;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_active;
  rgb_t       r_rgb;
  logic [9:0] r_pix_x;
  logic [9:0] r_pix_y;
  logic       r_frame_start;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .clk         (Clk),
    .rst         (Reset),
    .o_pix_en    (w_pix_en),
    .o_hcnt      (w_hcnt),
    .o_vcnt      (w_vcnt),
    .o_hsync_n   (w_hsync_n),
    .o_vsync_n   (w_vsync_n),
    .o_active    (w_active),
    .o_frame_end (w_frame_end)
  );

  // Position is captured on the very last tick so a frame never tears.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_x_q <= 1'b0;
      r_y_q <= 1'b0;
    end else if (w_pix_en && w_frame_end) begin
      r_x_q <= X;
      r_y_q <= Y;
    end
  end

  always_comb begin
    w_rgb = COLOR_BLACK;
    if (!w_active) begin
      w_rgb = COLOR_BLACK;
    end else if ((w_hcnt == 10'(H_ACTIVE/2 - 1)) || (w_hcnt == 10'(H_ACTIVE/2)) ||
                 (w_vcnt == 10'(V_ACTIVE/2 - 1)) || (w_vcnt == 10'(V_ACTIVE/2))) begin
      w_rgb = GRID_RGB;
    end else if (((w_hcnt >= 10'(H_ACTIVE/2)) == r_x_q) &&
                 ((w_vcnt <  10'(V_ACTIVE/2)) == r_y_q)) begin
      w_rgb = PLAYER_RGB;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_active      <= 1'b0;
      r_rgb         <= COLOR_BLACK;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_pix_en && (w_hcnt == 10'd0) && (w_vcnt == 10'd0);
      if (w_pix_en) begin
        r_hsync  <= w_hsync_n;
        r_vsync  <= w_vsync_n;
        r_active <= w_active;
        r_rgb    <= w_rgb;
        r_pix_x  <= w_hcnt;
        r_pix_y  <= w_vcnt;
      end
    end
  end

  assign HSync      = r_hsync;
  assign VSync      = r_vsync;
  assign Active     = r_active;
  assign Red        = r_rgb.r;
  assign Green      = r_rgb.g;
  assign Blue       = r_rgb.b;
  assign PixelX     = r_pix_x;
  assign PixelY     = r_pix_y;
  assign FrameStart = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_grid_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_grid_renderer
// Purpose  : Self-checking bench for vga_grid_renderer on a reduced raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_grid_renderer;

  localparam int TH_A = 32, TH_FP = 2, TH_S = 4, TH_BP = 2;
  localparam int TV_A = 24, TV_FP = 1, TV_S = 2, TV_BP = 3;
  localparam int CLK_DIV   = 2;
  localparam int HT        = TH_A + TH_FP + TH_S + TH_BP;
  localparam int VT        = TV_A + TV_FP + TV_S + TV_BP;
  localparam int FRAME_CYC = HT * VT * CLK_DIV;
  localparam logic [35:0] RST_BUNDLE = {1'b1, 1'b1, 1'b0, 12'h000, 10'd0, 10'd0, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x   = 1'b0;
  logic       y   = 1'b0;
  logic       hsync, vsync, active, frame_start;
  logic [3:0] red, green, blue;
  logic [9:0] pix_x, pix_y;
  logic [35:0] obs;

  int n_checks = 0;
  int n_pass   = 0;
  logic [35:0] sb[$];

  always #5 clk = ~clk;

  vga_grid_renderer #(
    .H_ACTIVE (TH_A), .H_FP (TH_FP), .H_SYNC (TH_S), .H_BP (TH_BP),
    .V_ACTIVE (TV_A), .V_FP (TV_FP), .V_SYNC (TV_S), .V_BP (TV_BP),
    .CLK_DIV  (CLK_DIV)
  ) dut (
    .Clk (clk), .Reset (rst), .X (x), .Y (y),
    .HSync (hsync), .VSync (vsync), .Red (red), .Green (green), .Blue (blue),
    .Active (active), .PixelX (pix_x), .PixelY (pix_y), .FrameStart (frame_start)
  );

  assign obs = {hsync, vsync, active, red, green, blue, pix_x, pix_y, frame_start};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: predicts the registered outputs for every Clk cycle.
  initial begin : model
    int m_div, m_h, m_v;
    bit m_xq, m_yq;
    logic [11:0] m_rgb;
    logic [35:0] m_out;
    m_div = 0; m_h = 0; m_v = 0; m_xq = 0; m_yq = 0; m_out = RST_BUNDLE;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_div = 0; m_h = 0; m_v = 0; m_xq = 0; m_yq = 0; m_out = RST_BUNDLE;
        sb.delete();
      end else begin
        m_out[0] = 1'b0;
        if (m_div == CLK_DIV - 1) begin
          m_div = 0;
          if (!(m_h < TH_A && m_v < TV_A)) m_rgb = 12'h000;
          else if (m_h == TH_A/2-1 || m_h == TH_A/2 || m_v == TV_A/2-1 || m_v == TV_A/2)
            m_rgb = 12'hFFF;
          else if (((m_h >= TH_A/2) == m_xq) && ((m_v < TV_A/2) == m_yq)) m_rgb = 12'hF00;
          else m_rgb = 12'h000;
          m_out = {!(m_h >= TH_A+TH_FP && m_h < TH_A+TH_FP+TH_S),
                   !(m_v >= TV_A+TV_FP && m_v < TV_A+TV_FP+TV_S),
                   (m_h < TH_A && m_v < TV_A), m_rgb, 10'(m_h), 10'(m_v),
                   (m_h == 0 && m_v == 0)};
          if (m_h == HT-1 && m_v == VT-1) begin m_xq = x; m_yq = y; end
          if (m_h == HT-1) begin m_h = 0; m_v = (m_v == VT-1) ? 0 : m_v + 1; end
          else m_h++;
        end else begin
          m_div++;
        end
        sb.push_back(m_out);
      end
    end
  end

  initial begin : scoreboard
    forever begin
      @(negedge clk);
      if (rst) chk("reset_outputs", obs, RST_BUNDLE);
      else if (sb.size() > 0) chk("pixel_bundle", obs, sb.pop_front());
    end
  end

  task automatic wait_pix(input int px, input int py, output bit ok);
    ok = 0;
    for (int i = 0; i < 2*FRAME_CYC; i++) begin
      @(posedge clk); #1;
      if (pix_x == 10'(px) && pix_y == 10'(py)) begin ok = 1; break; end
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 0;
    for (int i = 0; i < 2*FRAME_CYC; i++) begin
      @(posedge clk); #1;
      if (frame_start) begin ok = 1; break; end
    end
  endtask

  task automatic probe(input string tag, input int px, input int py, input logic [11:0] exp);
    bit ok;
    wait_pix(px, py, ok);
    if (!ok) chk({tag, "_timeout"}, 0, 1);
    else chk(tag, {red, green, blue}, exp);
  endtask

  // Counts Clk cycles from one FrameStart to the next, tracking sync windows.
  task automatic measure_frame(output int cyc, output int hs_low, output int vs_low,
                               output int hs_bad, output int vs_bad);
    cyc = 0; hs_low = 0; vs_low = 0; hs_bad = 0; vs_bad = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (!hsync != (pix_x >= 10'(TH_A+TH_FP) && pix_x < 10'(TH_A+TH_FP+TH_S))) hs_bad++;
      if (!vsync != (pix_y >= 10'(TV_A+TV_FP) && pix_y < 10'(TV_A+TV_FP+TV_S))) vs_bad++;
    end while (!frame_start && cyc < 2*FRAME_CYC);
  endtask

  initial begin : stimulus
    bit ok;
    int cyc, hs_low, vs_low, hs_bad, vs_bad;

    repeat (5) @(posedge clk);
    #1;
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_rgb", {red, green, blue}, 12'h000);
    chk("rst_active", active, 1'b0);
    chk("rst_pixel", {pix_x, pix_y}, 20'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; chk("first_tick_not_yet", frame_start, 1'b0);
    @(posedge clk); #1; chk("first_tick_fs", frame_start, 1'b1);

    x = 1'b1; y = 1'b1;
    measure_frame(cyc, hs_low, vs_low, hs_bad, vs_bad);
    chk("frame_period", cyc, FRAME_CYC);
    chk("hsync_window", hs_bad, 0);
    chk("vsync_window", vs_bad, 0);
    chk("hsync_low_cycles", hs_low, TH_S * VT * CLK_DIV);
    chk("vsync_low_cycles", vs_low, TV_S * HT * CLK_DIV);

    probe("x1y1_left_upper", 5, 5, 12'h000);
    probe("x1y1_right_upper", 25, 5, 12'hF00);
    probe("x1y1_vgrid", 16, 8, 12'hFFF);
    probe("x1y1_hgrid", 5, 11, 12'hFFF);
    probe("x1y1_blank", 36, 8, 12'h000);

    @(negedge clk); x = 1'b0; y = 1'b0;
    wait_fs(ok);
    chk("fs_seen_x0y0", ok, 1'b1);
    probe("x0y0_right_upper", 25, 5, 12'h000);
    probe("x0y0_left_lower", 5, 20, 12'hF00);

    wait_pix(0, 8, ok);
    chk("toggle_point", ok, 1'b1);
    @(negedge clk); x = 1'b1;
    probe("toggle_same_left", 5, 18, 12'hF00);
    probe("toggle_same_right", 25, 18, 12'h000);
    probe("toggle_next_left", 5, 18, 12'h000);
    probe("toggle_next_right", 25, 18, 12'hF00);

    wait_pix(18, 18, ok);
    chk("reset_point", ok, 1'b1);
    #2 rst = 1'b1;
    #1 chk("async_reset", obs, RST_BUNDLE);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1; chk("restart_not_yet", frame_start, 1'b0);
    @(posedge clk); #1; chk("restart_fs", frame_start, 1'b1);
    chk("restart_origin", {pix_x, pix_y}, 20'd0);
    measure_frame(cyc, hs_low, vs_low, hs_bad, vs_bad);
    chk("restart_period", cyc, FRAME_CYC);
    probe("post_reset_latched", 25, 18, 12'hF00);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
